// File: rtl/instr_byte_decoder_pkg.sv
// Instruction-set definitions shared by the byte-serial decoder: opcodes,
// size encodings, the expanded instruction record and decode helpers.
package instr_byte_decoder_pkg;

  typedef logic [3:0] arg_size_t;

  localparam arg_size_t BITS_8  = 4'd0;
  localparam arg_size_t BITS_16 = 4'd1;
  localparam arg_size_t BITS_32 = 4'd2;
  localparam arg_size_t BITS_64 = 4'd3;

  localparam logic [15:0] OP_NOP     = 16'd0;
  localparam logic [15:0] OP_LOAD    = 16'd1;
  localparam logic [15:0] OP_STORE   = 16'd2;
  localparam logic [15:0] OP_STOREIF = 16'd3;
  localparam logic [15:0] OP_MOV     = 16'd4;
  localparam logic [15:0] OP_JMP     = 16'd5;
  localparam logic [15:0] OP_BRA     = 16'd6;
  localparam logic [15:0] OP_CMP     = 16'd7;
  localparam logic [15:0] OP_ADD     = 16'd8;
  localparam logic [15:0] OP_SUB     = 16'd9;
  localparam logic [15:0] OP_MUL     = 16'd10;
  localparam logic [15:0] OP_AND     = 16'd11;
  localparam logic [15:0] OP_OR      = 16'd12;
  localparam logic [15:0] OP_XOR     = 16'd13;
  localparam logic [15:0] OP_SHL     = 16'd14;
  localparam logic [15:0] OP_SHR     = 16'd15;
  localparam logic [15:0] OP_BIT     = 16'd16;
  localparam logic [15:0] OP_SETF    = 16'd17;
  localparam logic [15:0] OP_CLEARF  = 16'd18;
  localparam logic [15:0] OP_HALT    = 16'd19;

  localparam logic [15:0] OPCODE_COUNT = 16'd20;

  typedef enum logic [1:0] {
    DEC_OK         = 2'd0,
    DEC_BAD_OPCODE = 2'd1,
    DEC_BAD_SIZE   = 2'd2
  } decode_err_t;

  typedef struct packed {
    logic [15:0]      opcode;
    arg_size_t [3:0]  arg_size;
    logic [7:0]       flags;
    logic [3:0][63:0] args;
  } instruction_t;

  // Opcodes that reuse flag bits 4-7 for their own meaning, so never sign-extend.
  function automatic logic SIGNEXT_EXEMPT(input logic [15:0] op);
    logic exempt;
    case (op)
      OP_JMP, OP_BRA, OP_LOAD, OP_STORE, OP_STOREIF, OP_BIT, OP_SETF, OP_CLEARF: exempt = 1'b1;
      default: exempt = 1'b0;
    endcase
    return exempt;
  endfunction

  function automatic logic [5:0] instr_enc_len(input arg_size_t [3:0] sizes);
    logic [6:0] total;
    total = 7'd5;
    for (int i = 0; i < 4; i++) begin
      total = total + (7'd1 << sizes[i][1:0]);
    end
    return total[5:0];
  endfunction

endpackage

// File: rtl/instr_byte_decoder_arg_extender.sv
// Combinational widening of a raw little-endian argument accumulator to 64 bits,
// zero- or sign-extended from its encoded width.
module arg_extender
  import instr_byte_decoder_pkg::*;
(
  input  logic [63:0] raw,
  input  arg_size_t   size,
  input  logic        sign_en,
  output logic [63:0] arg
);

  // Replicate the top bit of the encoded width only when sign extension is asked for.
  always_comb begin
    arg = raw;
    case (size)
      BITS_8:  arg = {{56{sign_en & raw[7]}},  raw[7:0]};
      BITS_16: arg = {{48{sign_en & raw[15]}}, raw[15:0]};
      BITS_32: arg = {{32{sign_en & raw[31]}}, raw[31:0]};
      BITS_64: arg = raw;
      default: arg = raw;
    endcase
  end

endmodule

// File: rtl/instr_byte_decoder.sv
// Byte-serial instruction decoder: assembles instruction_t from the encoded stream.
// Optional sign extension of args is enabled by defining INSTR_DECODER_SIGN_EXTEND_EN.
module instr_byte_decoder
  import instr_byte_decoder_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output instruction_t out_instr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   out_err,
  output logic [5:0]   out_len
);

  localparam logic [1:0] ST_HDR   = 2'd0;
  localparam logic [1:0] ST_ARG   = 2'd1;
  localparam logic [1:0] ST_EMIT  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  logic [1:0]   state_r;
  logic [2:0]   hdr_cnt_r;
  logic [1:0]   arg_idx_r;
  logic [2:0]   byte_idx_r;
  logic [63:0]  acc_r;
  logic [5:0]   len_r;
  logic         valid_r;
  decode_err_t  err_r;
  instruction_t instr_r;

  logic         in_ready_s;
  logic         accept_s;
  arg_size_t    cur_size_s;
  logic [2:0]   last_idx_s;
  logic         last_byte_s;
  logic [63:0]  acc_merged_s;
  logic [63:0]  arg_ext_s;
  logic         sign_en_s;
  logic [5:0]   len_inc_s;

  assign in_ready_s  = !flush && ((state_r == ST_HDR) || (state_r == ST_ARG));
  assign accept_s    = in_valid && in_ready_s;
  assign cur_size_s  = instr_r.arg_size[arg_idx_r];
  assign last_byte_s = (byte_idx_r == last_idx_s);
  assign len_inc_s   = (len_r == 6'd63) ? len_r : len_r + 6'd1;

  // Index of the final byte of the arg currently being collected.
  always_comb begin
    case (cur_size_s)
      BITS_8:  last_idx_s = 3'd0;
      BITS_16: last_idx_s = 3'd1;
      BITS_32: last_idx_s = 3'd3;
      default: last_idx_s = 3'd7;
    endcase
  end

  // Accumulator with the incoming byte dropped into its little-endian lane.
  always_comb begin
    acc_merged_s = acc_r;
    acc_merged_s[{byte_idx_r, 3'b000} +: 8] = in_data;
  end

`ifdef INSTR_DECODER_SIGN_EXTEND_EN
  assign sign_en_s = instr_r.flags[3'd4 + {1'b0, arg_idx_r}] && !SIGNEXT_EXEMPT(instr_r.opcode);
`else
  assign sign_en_s = 1'b0;
`endif

  arg_extender u_arg_extender (
    .raw     (acc_merged_s),
    .size    (cur_size_s),
    .sign_en (sign_en_s),
    .arg     (arg_ext_s)
  );

  // Decode FSM: header, args, emit handshake, and the sticky fault after a bad size.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_HDR;
      hdr_cnt_r  <= 3'd0;
      arg_idx_r  <= 2'd0;
      byte_idx_r <= 3'd0;
      acc_r      <= 64'd0;
      len_r      <= 6'd0;
      valid_r    <= 1'b0;
      err_r      <= DEC_OK;
      instr_r    <= '0;
    end else if (flush) begin
      state_r    <= ST_HDR;
      hdr_cnt_r  <= 3'd0;
      arg_idx_r  <= 2'd0;
      byte_idx_r <= 3'd0;
      acc_r      <= 64'd0;
      len_r      <= 6'd0;
      valid_r    <= 1'b0;
      err_r      <= DEC_OK;
    end else begin
      case (state_r)
        ST_HDR: begin
          if (accept_s) begin
            len_r     <= len_inc_s;
            hdr_cnt_r <= hdr_cnt_r + 3'd1;
            case (hdr_cnt_r)
              3'd0: begin
                instr_r              <= '0;
                instr_r.opcode[7:0]  <= in_data;
              end
              3'd1: instr_r.opcode[15:8] <= in_data;
              3'd2, 3'd3: begin
                instr_r.arg_size[{hdr_cnt_r[0], 1'b0}] <= in_data[3:0];
                instr_r.arg_size[{hdr_cnt_r[0], 1'b1}] <= in_data[7:4];
                // Any size nibble above BITS_64 aborts the instruction right here.
                if ((in_data[3:0] > BITS_64) || (in_data[7:4] > BITS_64)) begin
                  state_r   <= ST_EMIT;
                  hdr_cnt_r <= 3'd0;
                  valid_r   <= 1'b1;
                  err_r     <= DEC_BAD_SIZE;
                end
              end
              3'd4: begin
                instr_r.flags <= in_data;
                state_r       <= ST_ARG;
                hdr_cnt_r     <= 3'd0;
                arg_idx_r     <= 2'd0;
                byte_idx_r    <= 3'd0;
                acc_r         <= 64'd0;
              end
              default: hdr_cnt_r <= 3'd0;
            endcase
          end
        end
        ST_ARG: begin
          if (accept_s) begin
            len_r <= len_inc_s;
            if (last_byte_s) begin
              instr_r.args[arg_idx_r] <= arg_ext_s;
              acc_r      <= 64'd0;
              byte_idx_r <= 3'd0;
              if (arg_idx_r == 2'd3) begin
                state_r <= ST_EMIT;
                valid_r <= 1'b1;
                err_r   <= (instr_r.opcode >= OPCODE_COUNT) ? DEC_BAD_OPCODE : DEC_OK;
              end else begin
                arg_idx_r <= arg_idx_r + 2'd1;
              end
            end else begin
              acc_r      <= acc_merged_s;
              byte_idx_r <= byte_idx_r + 3'd1;
            end
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            valid_r <= 1'b0;
            len_r   <= 6'd0;
            err_r   <= DEC_OK;
            state_r <= (err_r == DEC_BAD_SIZE) ? ST_FAULT : ST_HDR;
          end
        end
        ST_FAULT: state_r <= ST_FAULT;
        default:  state_r <= ST_HDR;
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = valid_r;
  assign out_err   = err_r;
  assign out_len   = len_r;
  assign out_instr = instr_r;

endmodule

// File: tb/tb_instr_byte_decoder.sv
// Self-checking bench for instr_byte_decoder: directed cases plus random
// instructions checked against a field-level reference model.
module tb_instr_byte_decoder;
  import instr_byte_decoder_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  instruction_t out_instr;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_err;
  logic [5:0]   out_len;

  int checks = 0;
  int errors = 0;

  localparam logic [295:0] MASK_ALL  = {296{1'b1}};
  localparam logic [295:0] MASK_ARGS = {40'd0, {256{1'b1}}};

  always #5 clk = ~clk;

  instr_byte_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_instr (out_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_err   (out_err),
    .out_len   (out_len)
  );

  task automatic chk(input string tag, input logic [295:0] got, input logic [295:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arg value: truncate to n bytes, then optionally reinterpret as signed.
  function automatic logic [63:0] ref_arg(input logic [63:0] v, input int nbytes, input logic sx);
    int bits;
    logic [63:0] m;
    bits = nbytes * 8;
    if (bits == 64) return v;
    m = v % (64'd1 << bits);
    if (sx && (m >= (64'd1 << (bits - 1)))) m = m - (64'd1 << bits);
    return m;
  endfunction

  function automatic logic ref_sign(input logic [15:0] op, input logic [7:0] flags, input int i);
`ifdef INSTR_DECODER_SIGN_EXTEND_EN
    return flags[4 + i] && !(op inside {OP_JMP, OP_BRA, OP_LOAD, OP_STORE, OP_STOREIF,
                                        OP_BIT, OP_SETF, OP_CLEARF});
`else
    return 1'b0;
`endif
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    if ($urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("in_ready_timeout", 296'(in_ready), 296'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input instruction_t ei, input logic [1:0] ee,
                           input int el, input int hold, input logic [295:0] mask);
    chk({tag, "_valid"}, 296'(out_valid), 296'd1);
    chk({tag, "_err"}, 296'(out_err), 296'(ee));
    chk({tag, "_len"}, 296'(out_len), 296'(el));
    chk({tag, "_instr"}, out_instr & mask, ei & mask);
    repeat (hold) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 296'(out_valid), 296'd1);
      chk({tag, "_hold_in_ready"}, 296'(in_ready), 296'd0);
      chk({tag, "_hold_instr"}, out_instr & mask, ei & mask);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, 296'(out_valid), 296'd0);
  endtask

  // sizes holds the four size nibbles {s3,s2,s1,s0}; args holds {arg3,arg2,arg1,arg0}.
  task automatic run_instr(input string tag, input logic [15:0] op, input logic [15:0] sizes,
                           input logic [7:0] flags, input logic [255:0] args, input int hold);
    logic [7:0] q[$];
    instruction_t ei;
    int n;
    ei = '0;
    ei.opcode = op;
    ei.flags  = flags;
    q.push_back(op[7:0]);
    q.push_back(op[15:8]);
    q.push_back(sizes[7:0]);
    q.push_back(sizes[15:8]);
    q.push_back(flags);
    for (int i = 0; i < 4; i++) begin
      n = 1 << sizes[4*i +: 2];
      ei.arg_size[i] = sizes[4*i +: 4];
      for (int b = 0; b < n; b++) q.push_back(args[64*i + 8*b +: 8]);
      ei.args[i] = ref_arg(args[64*i +: 64], n, ref_sign(op, flags, i));
    end
    for (int k = 0; k < q.size(); k++) send_byte(q[k]);
    check_out(tag, ei, (op >= OPCODE_COUNT) ? 2'd1 : 2'd0, q.size(), hold, MASK_ALL);
  endtask

  task automatic run_bad(input string tag, input logic [15:0] op, input logic [7:0] b2,
                         input logic [7:0] b3, input logic use_b3);
    int n;
    send_byte(op[7:0]);
    send_byte(op[15:8]);
    send_byte(b2);
    n = 3;
    if (use_b3) begin
      send_byte(b3);
      n = 4;
    end
    check_out(tag, '0, 2'd2, n, 1, MASK_ARGS);
    in_data  = 8'h00;
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk({tag, "_fault_in_ready"}, 296'(in_ready), 296'd0);
      chk({tag, "_fault_valid"}, 296'(out_valid), 296'd0);
    end
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    run_instr({tag, "_nop"}, OP_NOP, 16'h0000, 8'h00, {64'h4, 64'h3, 64'h2, 64'h1}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 296'(in_ready), 296'd1);
    chk("rst_out_valid", 296'(out_valid), 296'd0);
    chk("rst_out_err", 296'(out_err), 296'd0);
    chk("rst_out_len", 296'(out_len), 296'd0);
    chk("rst_out_instr", out_instr, 296'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_instr("nop", OP_NOP, 16'h0000, 8'h00, {64'h44, 64'h33, 64'h22, 64'h11}, 0);
    run_instr("add_sx", OP_ADD, 16'h0000, 8'h10, {64'h0, 64'h0, 64'h0, 64'h80}, 1);
    run_instr("wide", OP_MOV, 16'h3333, 8'h00, {4{64'h0123456789ABCDEF}}, 5);
    run_instr("bad_op", 16'hFFFF, 16'h1111, 8'h00, {64'hBEEF, 64'h1234, 64'hA5A5, 64'h00FF}, 0);
    run_bad("bad_size", OP_NOP, 8'h04, 8'h00, 1'b0);
    run_bad("bad_size3", OP_ADD, 8'h21, 8'hF0, 1'b1);

    // Flush with the first arg byte on the bus: it must not be consumed.
    for (int k = 0; k < 5; k++) send_byte(8'h00);
    in_data  = 8'hAA;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 296'(in_ready), 296'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 296'(out_valid), 296'd0);
    run_instr("post_flush", OP_NOP, 16'h0000, 8'h00, {64'h44, 64'h33, 64'h22, 64'h11}, 0);

    for (int t = 0; t < 40; t++) begin
      logic [15:0]  op;
      logic [15:0]  sz;
      logic [255:0] a;
      op = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 22));
      sz = {2'b00, 2'($urandom), 2'b00, 2'($urandom), 2'b00, 2'($urandom), 2'b00, 2'($urandom)};
      a  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_instr("rnd", op, sz, 8'($urandom), a, $urandom_range(0, 2));
      if (t % 10 == 9) run_bad("rnd_bad", op, {4'($urandom_range(4, 15)), 4'd0}, 8'h00, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_byte_decoder.md
# instr_byte_decoder

Byte-serial instruction decoder between the fetch unit and the execute stage. It accepts the variable-length encoded instruction stream one byte per cycle, assembles a fully expanded `instruction_t` (opcode, four size fields, flags, four 64-bit args), and presents it to execute over a valid/ready handshake. It reports the consumed byte length for PC advance and flags malformed encodings.

## Interface
- No parameters. All widths come from `types`/`instructions` packages.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous discard of any partial or pending instruction.
- `in_data` in 8: encoded byte.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: byte accepted when `in_valid && in_ready`.
- `out_instr` out `instruction_t` (296): decoded instruction.
- `out_valid` out 1: `out_instr`/`out_err`/`out_len` valid.
- `out_ready` in 1: consumer accepts on `out_valid && out_ready`.
- `out_err` out 2: 0 ok, 1 bad opcode, 2 bad size.
- `out_len` out 6: encoded bytes consumed (9..37).

## Operation
- Encoding is little-endian, in this order:
  - byte0 = `opcode[7:0]`, byte1 = `opcode[15:8]`.
  - byte2 = `{argSize1,argSize0}`, byte3 = `{argSize3,argSize2}`.
  - byte4 = `flags`.
  - Then arg0..arg3. Each arg is 2^argSize bytes, LSB first.
- States:
  - HDR: header byte counter 0..4.
  - ARG: arg index 0..3, byte index 0..7.
  - EMIT.
  - FAULT.
- HDR→ARG after byte4. ARG→EMIT after the last byte of arg3. EMIT→HDR on `out_ready`.
- Size check happens when byte2 (or byte3) is accepted. If either nibble is >3, the block goes directly to EMIT with `out_err`=2, args zero, `out_len`=bytes so far. After that handshake it goes to FAULT.
- FAULT: `in_ready`=0 and it stays there until `flush`.
- Opcode ≥ `OPCODE_COUNT`: the instruction is still consumed in full and emitted with `out_err`=1.
- Args are zero-extended to 64 bits. Sign extension is optional; see Configuration.
- `in_ready` = 1 in HDR/ARG, 0 in EMIT/FAULT.
- `out_valid` = 1 only in EMIT. Outputs are held stable while `out_valid && !out_ready`.
- `out_len` = 5 + Σ2^argSize_i. The byte counter saturates at 63 and cannot wrap.
- `flush` has priority over everything, including a same-cycle byte or handshake:
  - Next state HDR, counters cleared, `out_valid` dropped.
  - The byte presented in the flush cycle is not consumed (`in_ready` is forced 0).
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out_err`=0, `out_len`=0.
  - `out_instr` = all zero (opcode NOP).
  - State HDR.

## Timing
- One byte per cycle when `in_valid` is held high.
- When the last byte is accepted in cycle N, `out_valid`=1 in N+1.
- One bubble per instruction (EMIT). Throughput is len+1 cycles per instruction.
- Reset mid-instruction discards everything asynchronously.

## Configuration
- `INSTR_DECODER_SIGN_EXTEND_EN` defined:
  - Arg *i* is sign-extended from its encoded width when `flags[4+i]` is set.
  - Exception: opcodes in the exempt set are always zero-extended. The exempt set is JMP, BRA, LOAD, STORE, STOREIF, BIT, SETF, CLEARF, because those reuse flag bits 4–7.
- Undefined: all args are zero-extended and flags are passed through untouched.
- Flags are never modified in either case.

## Structure
- `instructions` package additions:
  - `OPCODE_COUNT` constant.
  - `SIGNEXT_EXEMPT` opcode check function.
  - `instr_enc_len` function (sizes → bytes).
  - `decode_err_t` enum (`DEC_OK`, `DEC_BAD_OPCODE`, `DEC_BAD_SIZE`).
- One sub-module, `arg_extender`: combinational, takes raw 64-bit accumulator, size, and sign flag; returns the extended arg. It is instantiated once and applied at arg completion.

## Test plan
- NOP, all sizes BITS_8, flags 0, stream `00 00 00 00 00 11 22 33 44` → one cycle after byte 9:
  - `out_valid`=1.
  - args 0x11/0x22/0x33/0x44.
  - `out_len`=9, `out_err`=0.
- ADD (opcode 8), argSize0=BITS_8, flags 0x10, arg0 byte 0x80, others BITS_8 zero:
  - arg0 = 0xFFFF_FFFF_FFFF_FF80 with the macro defined.
  - arg0 = 0x80 without it.
- All sizes BITS_64, args 0x0123456789ABCDEF pattern → `out_len`=37 and exact arg reassembly. Then hold `out_ready`=0 for 5 cycles → `in_ready`=0 and `out_instr` stable throughout.
- byte2=0x04 (argSize0=4):
  - Next cycle `out_valid`, `out_err`=2, `out_len`=3.
  - After acceptance, `in_ready`=0 until `flush`.
  - After `flush`, a NOP decodes normally.
- Opcode 0xFFFF, sizes BITS_16 → full 13 bytes consumed, `out_err`=1, `out_len`=13.
- `flush` asserted while in_valid=1 on byte 6 of an instruction → that byte is not consumed, no `out_valid`. The next 9-byte NOP decodes with `out_len`=9.
